// File: rtl/bfp_decomp_arb_if.sv
// bfp_decomp_arb_if
//   Bundles the NUM_PORTS compressed U-plane AXI-Stream sources (s_axis_*)
//   and the single stream toward the BFP decompressor (m_axis_*).
//
//   Source port i occupies tdata[64*i +: 64], tkeep[8*i +: 8],
//   tuser[40*i +: 40] and bit i of tvalid/tlast/tready.
//   tuser carries {udCompHdr, sectionHdr}; m_axis_tdest carries the source
//   port index of every forwarded beat.
//
//   Modports:
//     slave  - the arbiter: sink of s_axis_*, source of m_axis_*
//     master - the environment: sources and decompressor
interface bfp_decomp_arb_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_W      = 2
);
  logic [NUM_PORTS*64-1:0] s_axis_tdata;
  logic [NUM_PORTS*8-1:0]  s_axis_tkeep;
  logic [NUM_PORTS-1:0]    s_axis_tvalid;
  logic [NUM_PORTS-1:0]    s_axis_tlast;
  logic [NUM_PORTS-1:0]    s_axis_tready;
  logic [NUM_PORTS*40-1:0] s_axis_tuser;

  logic [63:0]             m_axis_tdata;
  logic [7:0]              m_axis_tkeep;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_axis_tready;
  logic [39:0]             m_axis_tuser;
  logic [ID_W-1:0]         m_axis_tdest;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tdest,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tdest,
    output m_axis_tready
  );
endinterface

// File: rtl/bfp_decomp_arb.sv
// bfp_decomp_arb
//   Packet-level round-robin arbiter sharing one BFP decompressor between
//   NUM_PORTS compressed U-plane AXI-Stream sources. One port is granted per
//   packet and the grant is held until that port's tlast beat is accepted.
//   Beats pass unchanged through a one-deep register slice and are tagged
//   with the source port index on m_axis_tdest.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            bfp_decomp_arb_if.slave (s_axis_* sources, m_axis_* sink)
//   ctrl_port_en   per-port enable, only consulted when choosing a grant
//   stat_busy      high while a packet transfer is in progress
//   err_stall      (BFP_DECOMP_ARB_STALL_EN only) one-cycle pulse when a
//                  granted source has idled STALL_CYCLES cycles mid-packet
//
// Optional feature macro: BFP_DECOMP_ARB_STALL_EN
//   Undefined: the grant is held indefinitely while a source idles.
//   Defined:   after STALL_CYCLES idle cycles a drain marker beat
//              (tlast = 1, tkeep = 0, tdest = grant) closes the packet and
//              arbitration moves on to the next port.
module bfp_decomp_arb #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned ID_W         = 2,
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bfp_decomp_arb_if.slave      bus,
  input  logic [NUM_PORTS-1:0] ctrl_port_en,
  output logic                 stat_busy
`ifdef BFP_DECOMP_ARB_STALL_EN
  ,
  output logic                 err_stall
`endif
);

  if (ID_W != $clog2(NUM_PORTS)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_PORTS)");
  end
  if (STALL_CYCLES == 0) begin : g_bad_stall
    $error("STALL_CYCLES must be nonzero");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]           state;
  logic [ID_W-1:0]      grant;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      pick;
  logic [ID_W-1:0]      idx;
  logic [ID_W-1:0]      nxt_ptr;
  logic [NUM_PORTS-1:0] req;
  logic                 req_any;

  logic                 slice_ready;
  logic                 accept;
  logic                 stall_hit;
  logic                 drain;

  logic [63:0]          sel_data;
  logic [7:0]           sel_keep;
  logic [39:0]          sel_user;
  logic                 sel_valid;
  logic                 sel_last;

  // Granted-port input mux
  assign sel_data  = bus.s_axis_tdata[64*grant +: 64];
  assign sel_keep  = bus.s_axis_tkeep[8*grant +: 8];
  assign sel_user  = bus.s_axis_tuser[40*grant +: 40];
  assign sel_valid = bus.s_axis_tvalid[grant];
  assign sel_last  = bus.s_axis_tlast[grant];

  // The slice can take a new beat when empty or when its beat leaves now
  assign slice_ready = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign accept      = (state == XFER) && sel_valid && slice_ready && !stall_hit;
  assign stat_busy   = (state == XFER);

  assign req     = bus.s_axis_tvalid & ctrl_port_en;
  assign nxt_ptr = (grant == ID_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

  // First requesting port at or after rr_ptr, searching cyclically
  always_comb begin
    pick    = rr_ptr;
    req_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = ID_W'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!req_any && req[idx]) begin
        req_any = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    bus.s_axis_tready = '0;
    if (state == XFER && !stall_hit) begin
      bus.s_axis_tready[grant] = slice_ready;
    end
  end

`ifdef BFP_DECOMP_ARB_STALL_EN
  localparam int unsigned CNT_W = $clog2(STALL_CYCLES + 1);

  logic [CNT_W-1:0] stall_cnt;

  assign stall_hit = (state == XFER) && (stall_cnt == CNT_W'(STALL_CYCLES));
  // The drain marker waits for room in the slice like any other beat
  assign drain     = stall_hit && slice_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      err_stall <= 1'b0;
    end else begin
      err_stall <= drain;
      if (state != XFER || sel_valid || drain) begin
        stall_cnt <= '0;
      end else if (!stall_hit) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end
`else
  assign stall_hit = 1'b0;
  assign drain     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      grant             <= '0;
      rr_ptr            <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tkeep  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= 1'b0;
      bus.m_axis_tuser  <= '0;
      bus.m_axis_tdest  <= '0;
    end else begin
      // Output register slice
      if (accept) begin
        bus.m_axis_tdata  <= sel_data;
        bus.m_axis_tkeep  <= sel_keep;
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tlast  <= sel_last;
        bus.m_axis_tuser  <= sel_user;
        bus.m_axis_tdest  <= grant;
      end else if (drain) begin
        bus.m_axis_tdata  <= '0;
        bus.m_axis_tkeep  <= '0;
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tlast  <= 1'b1;
        bus.m_axis_tuser  <= '0;
        bus.m_axis_tdest  <= grant;
      end else if (bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end

      // Packet-level arbitration
      case (state)
        IDLE: begin
          if (req_any) begin
            grant <= pick;
            state <= XFER;
          end
        end
        XFER: begin
          if ((accept && sel_last) || drain) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
